// File: rtl/arrayproc_pkg.sv
// Shared definitions for the array processor host side: sequencer state
// encoding and the register-address width used on the readback port.
package arrayproc_pkg;

    localparam int REG_AW = 10;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_RSET  = 3'd3,
        S_RWAIT = 3'd4,
        S_OUT   = 3'd5,
        S_DONE  = 3'd6
    } state_t;

endpackage

// File: rtl/array_host_sequencer_prog_ram.sv
// Program store: DEPTH x LENGTH, one synchronous write port and one
// asynchronous read port. Contents are not affected by reset.
module array_host_sequencer_prog_ram #(
    parameter int DEPTH  = 16,
    parameter int LENGTH = 32
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [LENGTH-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [LENGTH-1:0]        rdata
);

    logic [LENGTH-1:0] mem_q [DEPTH];

    // Single write port; gating against busy is done by the caller.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/array_host_sequencer.sv
// Host-side initiator for the array processor: replays a stored program
// (one start pulse per instruction, EXEC_CYCLES apart), then reads one
// register from every PE and streams the results out.
// Result port handshake: res_valid rises with res_pe/res_data stable and
// they stay frozen until a cycle with res_valid && res_ready, which is the
// transfer; res_valid drops on the following cycle.
module array_host_sequencer
    import arrayproc_pkg::*;
#(
    parameter int SIZE        = 5,
    parameter int LENGTH      = 32,
    parameter int DEPTH       = 16,
    parameter int EXEC_CYCLES = 1000,
    parameter int NUM_PE      = 32,
    parameter int READ_LAT    = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     prog_we,
    input  logic [$clog2(DEPTH)-1:0] prog_addr,
    input  logic [LENGTH-1:0]        prog_wdata,
    input  logic [$clog2(DEPTH):0]   prog_len,
    input  logic [REG_AW-1:0]        rd_reg,
    input  logic                     run,
    output logic [LENGTH-1:0]        instruction,
    output logic                     start,
    output logic [SIZE-1:0]          PE_Addr,
    output logic [REG_AW-1:0]        RegAddr,
    input  logic [15:0]              data,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [SIZE-1:0]          res_pe,
    output logic [15:0]              res_data,
    output logic                     busy,
    output logic                     done,
    output logic [2:0]               dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(EXEC_CYCLES);
    localparam int RW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    state_t            state_q, state_d;
    logic [LW-1:0]     pc_q, pc_d;
    logic [LW-1:0]     len_q, len_d;
    logic [REG_AW-1:0] rd_reg_q, rd_reg_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [RW-1:0]     rcnt_q, rcnt_d;
    logic [SIZE-1:0]   idx_q, idx_d;
    logic [LENGTH-1:0] instr_q, instr_d;
    logic              start_q, start_d;
    logic [SIZE-1:0]   pe_addr_q, pe_addr_d;
    logic [REG_AW-1:0] reg_addr_q, reg_addr_d;
    logic              res_valid_q, res_valid_d;
    logic [SIZE-1:0]   res_pe_q, res_pe_d;
    logic [15:0]       res_data_q, res_data_d;
    logic              done_q, done_d;

    logic              ram_we;
    logic [AW-1:0]     ram_raddr;
    logic [LENGTH-1:0] ram_rdata;
    logic [LW-1:0]     len_in;
    logic [LW-1:0]     pc_next;

    assign busy    = (state_q != S_IDLE);
    assign ram_we  = prog_we && !busy;
    // Only two fetches ever happen: slot 0 on run, slot pc+1 at the end of WAIT.
    assign ram_raddr = (state_q == S_WAIT) ? (pc_q[AW-1:0] + 1'b1) : '0;
    assign len_in    = (prog_len > LW'(DEPTH)) ? LW'(DEPTH) : prog_len;
    assign pc_next   = pc_q + 1'b1;

    array_host_sequencer_prog_ram #(
        .DEPTH  (DEPTH),
        .LENGTH (LENGTH)
    ) u_prog_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (prog_addr),
        .wdata (prog_wdata),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    // Next-state and next-output logic; outputs are loaded on entry to the
    // state they belong to so every port comes straight from a flop.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        len_d       = len_q;
        rd_reg_d    = rd_reg_q;
        cnt_d       = cnt_q;
        rcnt_d      = rcnt_q;
        idx_d       = idx_q;
        instr_d     = instr_q;
        start_d     = 1'b0;
        pe_addr_d   = pe_addr_q;
        reg_addr_d  = reg_addr_q;
        res_valid_d = res_valid_q;
        res_pe_d    = res_pe_q;
        res_data_d  = res_data_q;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run) begin
                    len_d    = len_in;
                    rd_reg_d = rd_reg;
                    pc_d     = '0;
                    if (len_in == '0) begin
                        state_d    = S_RSET;
                        pe_addr_d  = idx_q;
                        reg_addr_d = rd_reg;
                    end else begin
                        state_d = S_ISSUE;
                        instr_d = ram_rdata;
                        start_d = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                cnt_d   = CW'(EXEC_CYCLES - 2);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    pc_d = pc_next;
                    if (pc_next == len_q) begin
                        state_d    = S_RSET;
                        pe_addr_d  = idx_q;
                        reg_addr_d = rd_reg_q;
                    end else begin
                        state_d = S_ISSUE;
                        instr_d = ram_rdata;
                        start_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RSET: begin
                rcnt_d  = RW'(READ_LAT - 1);
                state_d = S_RWAIT;
            end
            S_RWAIT: begin
                if (rcnt_q == '0) begin
                    res_data_d  = data;
                    res_pe_d    = idx_q;
                    res_valid_d = 1'b1;
                    state_d     = S_OUT;
                end else begin
                    rcnt_d = rcnt_q - 1'b1;
                end
            end
            S_OUT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    if (idx_q == SIZE'(NUM_PE - 1)) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        idx_d   = '0;
                        pc_d    = '0;
                    end else begin
                        idx_d     = idx_q + 1'b1;
                        pe_addr_d = idx_q + 1'b1;
                        state_d   = S_RSET;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; async reset clears start/res_valid at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            len_q       <= '0;
            rd_reg_q    <= '0;
            cnt_q       <= '0;
            rcnt_q      <= '0;
            idx_q       <= '0;
            instr_q     <= '0;
            start_q     <= 1'b0;
            pe_addr_q   <= '0;
            reg_addr_q  <= '0;
            res_valid_q <= 1'b0;
            res_pe_q    <= '0;
            res_data_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            len_q       <= len_d;
            rd_reg_q    <= rd_reg_d;
            cnt_q       <= cnt_d;
            rcnt_q      <= rcnt_d;
            idx_q       <= idx_d;
            instr_q     <= instr_d;
            start_q     <= start_d;
            pe_addr_q   <= pe_addr_d;
            reg_addr_q  <= reg_addr_d;
            res_valid_q <= res_valid_d;
            res_pe_q    <= res_pe_d;
            res_data_q  <= res_data_d;
            done_q      <= done_d;
        end
    end

    assign instruction = instr_q;
    assign start       = start_q;
    assign PE_Addr     = pe_addr_q;
    assign RegAddr     = reg_addr_q;
    assign res_valid   = res_valid_q;
    assign res_pe      = res_pe_q;
    assign res_data    = res_data_q;
    assign done        = done_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_array_host_sequencer.sv
// Directed bench for array_host_sequencer with a READ_LAT-deep array model.
module tb_array_host_sequencer;
    import arrayproc_pkg::*;

    localparam int NUM_PE = 32;

    logic        clk;
    logic        reset;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [31:0] prog_wdata;
    logic [4:0]  prog_len;
    logic [9:0]  rd_reg;
    logic        run;
    logic [31:0] instruction;
    logic        start;
    logic [4:0]  PE_Addr;
    logic [9:0]  RegAddr;
    logic [15:0] data;
    logic        res_valid;
    logic        res_ready;
    logic [4:0]  res_pe;
    logic [15:0] res_data;
    logic        busy;
    logic        done;
    logic [2:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    logic [20:0] exp_q[$];
    int          start_cyc_q[$];
    logic [31:0] start_ins_q[$];
    logic [15:0] pipe0 = '0;
    logic [15:0] pipe1 = '0;

    array_host_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_wdata  (prog_wdata),
        .prog_len    (prog_len),
        .rd_reg      (rd_reg),
        .run         (run),
        .instruction (instruction),
        .start       (start),
        .PE_Addr     (PE_Addr),
        .RegAddr     (RegAddr),
        .data        (data),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_pe      (res_pe),
        .res_data    (res_data),
        .busy        (busy),
        .done        (done),
        .dbg_state   (dbg_state)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    // Array model: register contents are a fixed function of PE and address,
    // returned two clocks after the address is presented.
    function automatic logic [15:0] array_model(input logic [4:0] pe, input logic [9:0] ra);
        return {1'b1, pe, ra} ^ 16'h5A5A;
    endfunction

    always @(posedge clk) begin
        pipe0 <= array_model(PE_Addr, RegAddr);
        pipe1 <= pipe0;
    end
    assign data = pipe1;

    // Start pulse recorder
    always @(negedge clk) begin
        if (start === 1'b1) begin
            start_cyc_q.push_back(cycle);
            start_ins_q.push_back(instruction);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_prog(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        prog_we    = 1'b1;
        prog_addr  = a;
        prog_wdata = d;
        @(negedge clk);
        prog_we    = 1'b0;
    endtask

    task automatic do_run(input logic [4:0] len, input logic [9:0] ra);
        @(negedge clk);
        prog_len = len;
        rd_reg   = ra;
        run      = 1'b1;
        @(negedge clk);
        run      = 1'b0;
    endtask

    task automatic push_expected(input logic [9:0] ra);
        logic [4:0] p;
        for (int i = 0; i < NUM_PE; i++) begin
            p = 5'(i);
            exp_q.push_back({p, array_model(p, ra)});
        end
    endtask

    task automatic clear_monitors();
        start_cyc_q.delete();
        start_ins_q.delete();
    endtask

    // Drain all NUM_PE results; optionally stall the consumer on one PE.
    task automatic collect(input int stall_pe, input int first_bound);
        int          waited;
        int          bound;
        logic [20:0] e;
        logic [63:0] snap;
        for (int pe = 0; pe < NUM_PE; pe++) begin
            waited = 0;
            bound  = (pe == 0) ? first_bound : 10;
            while (res_valid !== 1'b1 && waited < bound) begin
                @(negedge clk);
                waited++;
            end
            if (res_valid !== 1'b1) begin
                check("res_valid_timeout", 64'(res_valid), 64'd1);
                return;
            end
            if (pe == stall_pe) begin
                res_ready = 1'b0;
                snap = 64'({res_valid, res_pe, res_data, PE_Addr, RegAddr});
                repeat (50) begin
                    @(negedge clk);
                    check("stall_hold", 64'({res_valid, res_pe, res_data, PE_Addr, RegAddr}), snap);
                end
                res_ready = 1'b1;
            end
            e = exp_q.pop_front();
            check("res_pe", 64'(res_pe), 64'(e[20:16]));
            check("res_data", 64'(res_data), 64'(e[15:0]));
            @(negedge clk);
            if (pe < NUM_PE - 1) begin
                check("next_pe_addr", 64'(PE_Addr), 64'(pe + 1));
                check("res_valid_drop", 64'(res_valid), 64'd0);
            end else begin
                check("done_pulse", 64'(done), 64'd1);
            end
        end
        @(negedge clk);
        check("done_single", 64'(done), 64'd0);
        check("busy_after_done", 64'(busy), 64'd0);
        check("state_idle_after_done", 64'(dbg_state), 64'(S_IDLE));
    endtask

    initial begin
        reset      = 1'b0;
        prog_we    = 1'b0;
        prog_addr  = '0;
        prog_wdata = '0;
        prog_len   = '0;
        rd_reg     = '0;
        run        = 1'b0;
        res_ready  = 1'b1;

        // 1: reset held 100 cycles, outputs quiet during and after
        repeat (50) @(negedge clk);
        check("reset_outputs_held", 64'({instruction, start, PE_Addr, RegAddr, res_valid,
              res_pe, res_data, busy, done, dbg_state}), 64'd0);
        repeat (50) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs_after", 64'({instruction, start, PE_Addr, RegAddr, res_valid,
              res_pe, res_data, busy, done, dbg_state}), 64'd0);
        check("no_start_after_reset", 64'(start_cyc_q.size()), 64'd0);

        // 2: single instruction then full sweep of register 0x20
        write_prog(4'd0, 32'h08883000);
        write_prog(4'd1, 32'h1234ABCD);
        write_prog(4'd2, 32'hCAFEF00D);
        clear_monitors();
        push_expected(10'h020);
        do_run(5'd1, 10'h020);
        check("busy_on_run", 64'(busy), 64'd1);
        collect(-1, 3000);
        check("t2_start_count", 64'(start_cyc_q.size()), 64'd1);
        if (start_ins_q.size() > 0) check("t2_start_instr", 64'(start_ins_q[0]), 64'h08883000);
        check("idle_keeps_instr", 64'(instruction), 64'h08883000);
        check("idle_keeps_pe_addr", 64'(PE_Addr), 64'd31);
        check("idle_keeps_regaddr", 64'(RegAddr), 64'h020);

        // 3 + 4: three instructions 1000 clocks apart, consumer stall at PE 7
        clear_monitors();
        push_expected(10'h2A5);
        do_run(5'd3, 10'h2A5);
        collect(7, 5000);
        check("t3_start_count", 64'(start_cyc_q.size()), 64'd3);
        if (start_cyc_q.size() >= 3) begin
            check("t3_spacing_01", 64'(start_cyc_q[1] - start_cyc_q[0]), 64'd1000);
            check("t3_spacing_12", 64'(start_cyc_q[2] - start_cyc_q[1]), 64'd1000);
            check("t3_instr0", 64'(start_ins_q[0]), 64'h08883000);
            check("t3_instr1", 64'(start_ins_q[1]), 64'h1234ABCD);
            check("t3_instr2", 64'(start_ins_q[2]), 64'hCAFEF00D);
        end

        // 5: empty program goes straight to readback; writes/run while busy dropped
        clear_monitors();
        push_expected(10'h155);
        do_run(5'd0, 10'h155);
        check("t5_state_rset", 64'(dbg_state), 64'(S_RSET));
        check("t5_pe_addr", 64'(PE_Addr), 64'd0);
        check("t5_regaddr", 64'(RegAddr), 64'h155);
        @(negedge clk);
        prog_we    = 1'b1;
        prog_addr  = 4'd0;
        prog_wdata = 32'hDEADBEEF;
        prog_len   = 5'd3;
        rd_reg     = 10'h000;
        run        = 1'b1;
        @(negedge clk);
        prog_we = 1'b0;
        run     = 1'b0;
        collect(-1, 10);
        check("t5_no_start", 64'(start_cyc_q.size()), 64'd0);

        // 6a: reset while start is high
        do_run(5'd2, 10'h001);
        check("t6_start_high", 64'(start), 64'd1);
        #2 reset = 1'b0;
        #1;
        check("t6_start_async_drop", 64'(start), 64'd0);
        check("t6_state_idle_a", 64'(dbg_state), 64'(S_IDLE));
        @(negedge clk);
        reset = 1'b1;

        // 6b: reset during WAIT
        do_run(5'd2, 10'h001);
        repeat (20) @(negedge clk);
        check("t6_in_wait", 64'(dbg_state), 64'(S_WAIT));
        #2 reset = 1'b0;
        #1;
        check("t6_wait_reset", 64'({dbg_state, start, busy, instruction}), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // 6c: reset while a result is pending
        res_ready = 1'b0;
        do_run(5'd0, 10'h00F);
        repeat (4) @(negedge clk);
        check("t6_in_out", 64'({dbg_state, res_valid}), 64'({S_OUT, 1'b1}));
        #2 reset = 1'b0;
        #1;
        check("t6_res_valid_async_drop", 64'(res_valid), 64'd0);
        check("t6_state_idle_c", 64'(dbg_state), 64'(S_IDLE));
        @(negedge clk);
        reset     = 1'b1;
        res_ready = 1'b1;

        // 6d: fresh run uses the retained program
        clear_monitors();
        push_expected(10'h03C);
        do_run(5'd1, 10'h03C);
        collect(-1, 3000);
        check("t6_start_count", 64'(start_cyc_q.size()), 64'd1);
        if (start_ins_q.size() > 0) check("t6_retained_instr", 64'(start_ins_q[0]), 64'h08883000);

        // 7: prog_len above DEPTH runs exactly DEPTH instructions
        for (int a = 3; a < 16; a++) write_prog(4'(a), 32'hA5000000 | 32'(a));
        clear_monitors();
        push_expected(10'h3FF);
        do_run(5'd20, 10'h3FF);
        collect(-1, 20000);
        check("t7_clamped_count", 64'(start_cyc_q.size()), 64'd16);
        if (start_ins_q.size() == 16) check("t7_last_instr", 64'(start_ins_q[15]), 64'hA500000F);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
